// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD receive model.
// Holds the opcode-class base values, DDRAM geometry, blank character,
// the decoded command-class enum and the cursor-step helper.
package lcd_pkg;

  localparam int         DDRAM_DEPTH = 32;
  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam logic [7:0] BLANK_CHAR  = 8'h20;

  // Lowest opcode of each command class; the class of a command byte is
  // set by its most significant 1 bit.
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPLAY = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_DATA,
    CLS_CLEAR,
    CLS_HOME,
    CLS_ENTRY,
    CLS_DISPLAY,
    CLS_SHIFT,
    CLS_FUNC,
    CLS_CGRAM,
    CLS_DDRAM,
    CLS_INVALID
  } cmd_class_e;

  // The 32 cells form one ring (line 1 = 0-15, line 2 = 16-31), so plain
  // 5-bit wrap gives 15->16, 31->0, 16->15 and 0->31.
  function automatic logic [4:0] cursor_step(input logic [4:0] cur,
                                             input logic       inc);
    return inc ? cur + 5'd1 : cur - 5'd1;
  endfunction

endpackage

// File: rtl/lcd_rx_decode.sv
// Combinational classifier for one LCD bus transfer.
// Ports:
//   rs         in  1  0 = command byte, 1 = character data
//   data       in  8  byte on the bus
//   cls        out    command class (data, clear, home, entry, display,
//                     shift, function, CGRAM, DDRAM, invalid or no-op)
//   ddram_addr out 5  cursor target for a valid set-DDRAM-address command
module lcd_rx_decode
  import lcd_pkg::*;
(
  input  logic       rs,
  input  logic [7:0] data,
  output cmd_class_e cls,
  output logic [4:0] ddram_addr
);

  always_comb begin
    cls        = CLS_NOP;
    ddram_addr = '0;
    if (rs) begin
      cls = CLS_DATA;
    end else if (data >= CMD_DDRAM) begin
      // Only 0x00-0x0F (line 1) and 0x40-0x4F (line 2) exist on a 2x16 panel.
      if (data[6:4] == 3'b000) begin
        cls        = CLS_DDRAM;
        ddram_addr = {1'b0, data[3:0]};
      end else if (data[6:4] == LINE2_BASE[6:4]) begin
        cls        = CLS_DDRAM;
        ddram_addr = {1'b1, data[3:0]};
      end else begin
        cls = CLS_INVALID;
      end
    end else if (data >= CMD_CGRAM) begin
      cls = CLS_CGRAM;
    end else if (data >= CMD_FUNC) begin
      cls = CLS_FUNC;
    end else if (data >= CMD_SHIFT) begin
      cls = CLS_SHIFT;
    end else if (data >= CMD_DISPLAY) begin
      cls = CLS_DISPLAY;
    end else if (data >= CMD_ENTRY) begin
      cls = CLS_ENTRY;
    end else if (data >= CMD_HOME) begin
      cls = CLS_HOME;
    end else if (data == CMD_CLEAR) begin
      cls = CLS_CLEAR;
    end
  end

endmodule

// File: rtl/lcd_rx_model.sv
// Behavioural receiver model of a 2x16 character LCD controller.
// Captures command/data transfers, maintains a 32-cell DDRAM, cursor,
// entry mode, display-control and function-set bits, and reports
// unsupported commands and (optionally) overruns.
// Configuration macro: LCD_RX_BUSY_EN -- when defined, the model goes busy
// for CLEAR_CYCLES after a clear and CMD_CYCLES after any other transfer,
// and drops (flagging ovr_err) transfers that arrive while busy. When
// undefined, busy and ovr_err stay 0 and every strobe is accepted.
// Ports:
//   clk, rst (async, active high)
//   lcd_data[7:0], lcd_en, lcd_rs   LCD bus
//   rd_addr[4:0] -> rd_char[7:0]    DDRAM read-back, 1-cycle latency
//   err_clr                         clears cmd_err / ovr_err
//   cursor[4:0], display_on, cursor_on, blink_on, func_8bit, func_2line
//   busy, accept, cmd_err, ovr_err
module lcd_rx_model
  import lcd_pkg::*;
#(
  parameter int CLEAR_CYCLES = 16,
  parameter int CMD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lcd_data,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic [4:0] rd_addr,
  input  logic       err_clr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       func_8bit,
  output logic       func_2line,
  output logic       busy,
  output logic       accept,
  output logic       cmd_err,
  output logic       ovr_err
);

`ifdef LCD_RX_BUSY_EN
  localparam bit BusyModel = 1'b1;
`else
  localparam bit BusyModel = 1'b0;
`endif

  localparam logic [15:0] ClearLoad = 16'(CLEAR_CYCLES);
  localparam logic [15:0] CmdLoad   = 16'(CMD_CYCLES);

  cmd_class_e  cls;
  logic [4:0]  ddram_addr;
  logic [7:0]  ddram [DDRAM_DEPTH];
  logic        inc_mode;
  logic [15:0] busy_cnt;
  logic        take;
  logic        cmd_err_set;
  logic        ovr_err_set;

  lcd_rx_decode u_decode (
    .rs         (lcd_rs),
    .data       (lcd_data),
    .cls        (cls),
    .ddram_addr (ddram_addr)
  );

  // busy falls in the cycle the count reaches zero, so a strobe in that
  // cycle is already accepted. Without the busy model the count never loads.
  assign busy        = (busy_cnt != '0);
  assign take        = lcd_en && !busy;
  assign cmd_err_set = take && (cls == CLS_CGRAM || cls == CLS_INVALID);
  assign ovr_err_set = BusyModel && lcd_en && busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the DDRAM is reset because clear must rewrite all 32 cells in
      // one cycle anyway, so it is built from flops, not a RAM macro.
      for (int i = 0; i < DDRAM_DEPTH; i++) ddram[i] <= BLANK_CHAR;
      cursor     <= '0;
      inc_mode   <= 1'b1;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      func_8bit  <= 1'b0;
      func_2line <= 1'b0;
      accept     <= 1'b0;
      rd_char    <= 8'h00;
      cmd_err    <= 1'b0;
      ovr_err    <= 1'b0;
      busy_cnt   <= '0;
    end else begin
      // NOTE: non-blocking reads of ddram here see the pre-edge contents,
      // which gives read-old-value when a write hits the same cell.
      accept  <= take;
      rd_char <= ddram[rd_addr];

      // A new error wins over a simultaneous clear.
      if (cmd_err_set)  cmd_err <= 1'b1;
      else if (err_clr) cmd_err <= 1'b0;
      if (ovr_err_set)  ovr_err <= 1'b1;
      else if (err_clr) ovr_err <= 1'b0;

      if (take && BusyModel)   busy_cnt <= (cls == CLS_CLEAR) ? ClearLoad : CmdLoad;
      else if (busy_cnt != '0) busy_cnt <= busy_cnt - 16'd1;

      if (take) begin
        unique case (cls)
          CLS_DATA: begin
            ddram[cursor] <= lcd_data;
            cursor        <= cursor_step(cursor, inc_mode);
          end
          CLS_CLEAR: begin
            for (int i = 0; i < DDRAM_DEPTH; i++) ddram[i] <= BLANK_CHAR;
            cursor   <= '0;
            inc_mode <= 1'b1;
          end
          CLS_HOME:  cursor   <= '0;
          CLS_ENTRY: inc_mode <= lcd_data[1];
          CLS_DISPLAY: begin
            display_on <= lcd_data[2];
            cursor_on  <= lcd_data[1];
            blink_on   <= lcd_data[0];
          end
          CLS_SHIFT: begin
            // Display shift (bit3=1) is not modelled; only cursor moves.
            if (!lcd_data[3]) cursor <= cursor_step(cursor, lcd_data[2]);
          end
          CLS_FUNC: begin
            func_8bit  <= lcd_data[4];
            func_2line <= lcd_data[3];
          end
          CLS_DDRAM: cursor <= ddram_addr;
          CLS_NOP, CLS_CGRAM, CLS_INVALID: ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_rx_model.sv
// Directed self-checking bench for lcd_rx_model (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. Busy-model scenarios are selected by LCD_RX_BUSY_EN.
module tb_lcd_rx_model;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] lcd_data = 8'h00;
  logic       lcd_en = 1'b0;
  logic       lcd_rs = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       display_on, cursor_on, blink_on, func_8bit, func_2line;
  logic       busy, accept, cmd_err, ovr_err;

  int errors = 0;
  int checks = 0;

  string msg1 = "1 - N prem      ";
  string msg2 = "2 - Prem";

  lcd_rx_model dut (
    .clk(clk), .rst(rst), .lcd_data(lcd_data), .lcd_en(lcd_en),
    .lcd_rs(lcd_rs), .rd_addr(rd_addr), .err_clr(err_clr),
    .rd_char(rd_char), .cursor(cursor), .display_on(display_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .func_8bit(func_8bit),
    .func_2line(func_2line), .busy(busy), .accept(accept),
    .cmd_err(cmd_err), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  // All tasks start and end at a falling edge.
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
      errors++;
    end
    checks++;
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    wait_idle();
    lcd_en = 1'b1; lcd_rs = rs; lcd_data = d;
    @(posedge clk); #1;
    if (accept !== 1'b1) begin
      $display("FAIL send_accept rs=%0b data=%02h: accept=%b, required 1", rs, d, accept);
      errors++;
    end
    checks++;
    @(negedge clk);
    lcd_en = 1'b0;
  endtask

  task automatic read_cell(input logic [4:0] a, output logic [7:0] v);
    rd_addr = a;
    @(posedge clk); #1;
    v = rd_char;
    @(negedge clk);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    if ({cursor, busy, accept, cmd_err, ovr_err} !== 9'b0) begin
      $display("FAIL reset_state: cursor=%0d busy=%b accept=%b cmd_err=%b ovr_err=%b, required all 0",
               cursor, busy, accept, cmd_err, ovr_err);
      errors++;
    end
    checks++;
    if ({display_on, cursor_on, blink_on, func_8bit, func_2line} !== 5'b0) begin
      $display("FAIL reset_ctrl: bits=%b, required 00000",
               {display_on, cursor_on, blink_on, func_8bit, func_2line});
      errors++;
    end
    checks++;
    if (rd_char !== 8'h00) begin
      $display("FAIL reset_rd_char: got %02h, required 00", rd_char);
      errors++;
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    begin
      logic [7:0] v;
      read_cell(5'd7, v);
      if (v !== 8'h20) begin
        $display("FAIL reset_cell7: got %02h, required 20", v);
        errors++;
      end
      checks++;
    end
  endtask

  task automatic test_init();
    logic [7:0] v;
    send(1'b1, 8'h55);           // dirty a cell so the clear is observable
    send(1'b0, 8'h38);
    send(1'b0, 8'h0C);
    send(1'b0, 8'h01);
    if ({func_8bit, func_2line, display_on, cursor_on, blink_on} !== 5'b11100) begin
      $display("FAIL init_bits: f8=%b f2=%b d=%b c=%b b=%b, required 1 1 1 0 0",
               func_8bit, func_2line, display_on, cursor_on, blink_on);
      errors++;
    end
    checks++;
    for (int i = 0; i < 32; i += 31) begin
      read_cell(5'(i), v);
      if (v !== 8'h20) begin
        $display("FAIL init_cell%0d: got %02h, required 20", i, v);
        errors++;
      end
      checks++;
    end
    if (cursor !== 5'd0) begin
      $display("FAIL init_cursor: got %0d, required 0", cursor);
      errors++;
    end
    checks++;
  endtask

  task automatic test_message();
    logic [7:0] v;
    for (int i = 0; i < 16; i++) send(1'b1, msg1[i]);
    if (cursor !== 5'd16) begin
      $display("FAIL msg_line1_cursor: got %0d, required 16", cursor);
      errors++;
    end
    checks++;
    send(1'b0, 8'hC0);
    for (int i = 0; i < 8; i++) send(1'b1, msg2[i]);
    for (int i = 0; i < 16; i++) begin
      read_cell(5'(i), v);
      if (v !== msg1[i]) begin
        $display("FAIL msg_cell%0d: got %02h, required %02h", i, v, msg1[i]);
        errors++;
      end
      checks++;
    end
    for (int i = 0; i < 8; i++) begin
      read_cell(5'(16 + i), v);
      if (v !== msg2[i]) begin
        $display("FAIL msg_cell%0d: got %02h, required %02h", 16 + i, v, msg2[i]);
        errors++;
      end
      checks++;
    end
    if (cursor !== 5'd24) begin
      $display("FAIL msg_cursor: got %0d, required 24", cursor);
      errors++;
    end
    checks++;
  endtask

  task automatic test_read_during_write();
    send(1'b0, 8'h8A);           // cell 10 holds a padding space
    wait_idle();
    rd_addr = 5'd10;
    lcd_en = 1'b1; lcd_rs = 1'b1; lcd_data = 8'h5A;
    @(posedge clk); #1;
    if (rd_char !== 8'h20) begin
      $display("FAIL rw_same_old: got %02h, required 20", rd_char);
      errors++;
    end
    checks++;
    @(negedge clk);
    lcd_en = 1'b0;
    @(posedge clk); #1;
    if (rd_char !== 8'h5A) begin
      $display("FAIL rw_same_new: got %02h, required 5a", rd_char);
      errors++;
    end
    checks++;
    @(negedge clk);
  endtask

  task automatic test_cmd_err();
    send(1'b0, 8'h84);
    send(1'b0, 8'h40);
    if (cmd_err !== 1'b1 || cursor !== 5'd4) begin
      $display("FAIL cgram_err: cmd_err=%b cursor=%0d, required 1 4", cmd_err, cursor);
      errors++;
    end
    checks++;
    pulse_err_clr();
    if (cmd_err !== 1'b0) begin
      $display("FAIL err_clr: cmd_err=%b, required 0", cmd_err);
      errors++;
    end
    checks++;
    send(1'b0, 8'h00);
    if (cmd_err !== 1'b0) begin
      $display("FAIL nop_no_err: cmd_err=%b, required 0", cmd_err);
      errors++;
    end
    checks++;
    send(1'b0, 8'h90);           // DDRAM address 0x10 does not exist
    if (cmd_err !== 1'b1 || cursor !== 5'd4) begin
      $display("FAIL bad_ddram: cmd_err=%b cursor=%0d, required 1 4", cmd_err, cursor);
      errors++;
    end
    checks++;
    pulse_err_clr();
    wait_idle();
    err_clr = 1'b1; lcd_en = 1'b1; lcd_rs = 1'b0; lcd_data = 8'h7F;
    @(posedge clk); #1;
    if (cmd_err !== 1'b1) begin
      $display("FAIL err_clr_vs_set: cmd_err=%b, required 1", cmd_err);
      errors++;
    end
    checks++;
    @(negedge clk);
    lcd_en = 1'b0; err_clr = 1'b0;
    pulse_err_clr();
  endtask

  task automatic test_cursor_wrap();
    logic [7:0] v;
    send(1'b0, 8'hCF);
    send(1'b1, 8'h58);
    if (cursor !== 5'd0) begin
      $display("FAIL wrap_inc: cursor=%0d, required 0", cursor);
      errors++;
    end
    checks++;
    send(1'b0, 8'h04);
    send(1'b1, 8'h59);
    if (cursor !== 5'd31) begin
      $display("FAIL wrap_dec: cursor=%0d, required 31", cursor);
      errors++;
    end
    checks++;
    read_cell(5'd31, v);
    if (v !== 8'h58) begin
      $display("FAIL wrap_cell31: got %02h, required 58", v);
      errors++;
    end
    checks++;
    read_cell(5'd0, v);
    if (v !== 8'h59) begin
      $display("FAIL wrap_cell0: got %02h, required 59", v);
      errors++;
    end
    checks++;
    send(1'b0, 8'h06);
    send(1'b0, 8'h14);           // right: 31 -> 0
    send(1'b0, 8'h10);           // left:  0 -> 31
    send(1'b0, 8'h10);           // left:  31 -> 30
    send(1'b0, 8'h1C);           // display shift, cursor unchanged
    if (cursor !== 5'd30) begin
      $display("FAIL shift: cursor=%0d, required 30", cursor);
      errors++;
    end
    checks++;
    send(1'b0, 8'h03);
    send(1'b0, 8'h0B);
    send(1'b0, 8'h30);
    if ({cursor, display_on, cursor_on, blink_on, func_8bit, func_2line} !== {5'd0, 5'b01110}) begin
      $display("FAIL home_ctrl: cursor=%0d bits=%b, required 0 01110", cursor,
               {display_on, cursor_on, blink_on, func_8bit, func_2line});
      errors++;
    end
    checks++;
  endtask

`ifndef LCD_RX_BUSY_EN
  task automatic test_back_to_back();
    logic [7:0] v;
    lcd_en = 1'b1; lcd_rs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lcd_data = 8'h41 + 8'(i);
      @(posedge clk); #1;
      if (accept !== 1'b1 || busy !== 1'b0) begin
        $display("FAIL b2b_accept%0d: accept=%b busy=%b, required 1 0", i, accept, busy);
        errors++;
      end
      checks++;
      @(negedge clk);
    end
    lcd_en = 1'b0;
    if (cursor !== 5'd3 || ovr_err !== 1'b0) begin
      $display("FAIL b2b_cursor: cursor=%0d ovr_err=%b, required 3 0", cursor, ovr_err);
      errors++;
    end
    checks++;
    read_cell(5'd2, v);
    if (v !== 8'h43) begin
      $display("FAIL b2b_cell2: got %02h, required 43", v);
      errors++;
    end
    checks++;
  endtask
`else
  task automatic test_busy();
    logic [7:0] v;
    wait_idle();
    lcd_en = 1'b1; lcd_rs = 1'b0; lcd_data = 8'h01;
    @(posedge clk); #1;
    if (accept !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL busy_clear: accept=%b busy=%b, required 1 1", accept, busy);
      errors++;
    end
    checks++;
    @(negedge clk);
    lcd_rs = 1'b1; lcd_data = 8'h41;
    @(posedge clk); #1;
    if (accept !== 1'b0 || ovr_err !== 1'b1) begin
      $display("FAIL busy_drop: accept=%b ovr_err=%b, required 0 1", accept, ovr_err);
      errors++;
    end
    checks++;
    @(negedge clk);
    lcd_en = 1'b0;
    repeat (14) @(negedge clk);
    if (busy !== 1'b1) begin
      $display("FAIL busy_cycle15: busy=%b, required 1", busy);
      errors++;
    end
    checks++;
    @(negedge clk);
    if (busy !== 1'b0) begin
      $display("FAIL busy_cycle16: busy=%b, required 0", busy);
      errors++;
    end
    checks++;
    lcd_en = 1'b1;
    @(posedge clk); #1;
    if (accept !== 1'b1) begin
      $display("FAIL busy_cycle17_accept: accept=%b, required 1", accept);
      errors++;
    end
    checks++;
    @(negedge clk);
    lcd_en = 1'b0;
    read_cell(5'd0, v);
    if (v !== 8'h41 || cursor !== 5'd1) begin
      $display("FAIL busy_cell0: cell=%02h cursor=%0d, required 41 1", v, cursor);
      errors++;
    end
    checks++;
    pulse_err_clr();
    if (ovr_err !== 1'b0) begin
      $display("FAIL ovr_clr: ovr_err=%b, required 0", ovr_err);
      errors++;
    end
    checks++;
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] v;
    send(1'b1, 8'h77);
    send(1'b0, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    if (busy !== 1'b0 || cursor !== 5'd0 || accept !== 1'b0) begin
      $display("FAIL rst_async: busy=%b cursor=%0d accept=%b, required 0 0 0", busy, cursor, accept);
      errors++;
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    lcd_en = 1'b1; lcd_rs = 1'b1; lcd_data = 8'h51;
    @(posedge clk); #1;
    if (accept !== 1'b1 || cursor !== 5'd1) begin
      $display("FAIL rst_release_accept: accept=%b cursor=%0d, required 1 1", accept, cursor);
      errors++;
    end
    checks++;
    @(negedge clk);
    lcd_en = 1'b0;
    read_cell(5'd0, v);
    if (v !== 8'h51) begin
      $display("FAIL rst_release_cell0: got %02h, required 51", v);
      errors++;
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_message();
    test_read_during_write();
    test_cmd_err();
    test_cursor_wrap();
`ifndef LCD_RX_BUSY_EN
    test_back_to_back();
`else
    test_busy();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
